pwm_fade_engine: RTL and testbench
==================================

// Module: pwm_fade_engine
// PURPOSE
//  Multi-channel PWM fade sequencer for the on-board LED driver. One clock domain, no derived clocks.
//  A shared 6-segment colour-wheel sequence drives CHANNELS phase-offset ramp/hold profiles.
//  Each channel gets a glitch-free PWM output, with duty updated only at PWM period boundaries.
//  Sits between the top-level LED pins and the system clock.
// PARAMETERS
//  CHANNELS       3      number of fade channels
//  PWM_INTERVAL   1200   PWM period in clk cycles; full-scale level
//  STEP_INTERVAL  12000  clk cycles per fade step (1 ms at 12 MHz)
//  STEPS          200    fade steps per segment
//  CH_PHASE       2      segment offset between adjacent channels (mod 6)
//  derived: LW=$clog2(PWM_INTERVAL+1); STEP_VAL=PWM_INTERVAL/STEPS
//  elaboration $error unless STEP_VAL>=1, PWM_INTERVAL>=2, STEP_INTERVAL>=1
// PORTS
//  clk          in   1            system clock
//  rst_n        in   1            asynchronous reset, active-low
//  en           in   1            1: sequence advances; 0: prescaler/step/segment/levels frozen, PWM keeps running
//  restart      in   1            sync pulse: return sequence to segment 0 entry state
//  level_o      out  CHANNELS*LW  current per-channel fade level, ch c at [c*LW +: LW]
//  pwm_o        out  CHANNELS     registered PWM outputs
//  seg_o        out  3            current segment 0..5
//  seg_start_o  out  1            1-cycle pulse on the cycle seg_o changes (advance or wrap)
// BEHAVIOUR
//  Reset: prescaler, step_cnt, seg_o, pwm_cnt all 0; seg_start_o 0; pwm_o 0.
//  Reset: level_o and shadow duty = segment-0 entry values.
//  Entry values: HOLD_ON/RAMP_DN -> PWM_INTERVAL; HOLD_OFF/RAMP_UP -> 0.
//  Prescaler: counts 0..STEP_INTERVAL-1 while en=1. step_tick=1 when en=1 and prescaler==STEP_INTERVAL-1.
//  Step counter: on step_tick, step_cnt counts 0..STEPS-1.
//  Segment advance: at step_cnt==STEPS-1, step_cnt wraps to 0 and seg_o advances (5->0 wraps).
//    seg_start_o is registered with seg_o.
//  Profile P[k]: 0 HOLD_ON, 1 RAMP_DN, 2 HOLD_OFF, 3 HOLD_OFF, 4 RAMP_UP, 5 HOLD_ON.
//  Channel c kind = P[(seg_o + 6 - (CH_PHASE*c mod 6)) mod 6].
//  Level update on step_tick:
//    RAMP_UP  level = (step_cnt==STEPS-1) ? PWM_INTERVAL : min(level+STEP_VAL, PWM_INTERVAL)
//    RAMP_DN  level = (step_cnt==STEPS-1) ? 0 : max(level-STEP_VAL, 0); saturating, no wrap
//    HOLD_ON  level = PWM_INTERVAL
//    HOLD_OFF level = 0
//  Level arithmetic is done at LW+1 bits, then clamped.
//  PWM: pwm_cnt counts 0..PWM_INTERVAL-1 freely; it ignores en and restart.
//  Shadow duty: duty[c] <= level[c] on the cycle pwm_cnt==PWM_INTERVAL-1.
//  Output: pwm_o[c] <= (pwm_cnt < duty[c]). Level 0 gives constant 0; PWM_INTERVAL gives constant 1.
//  restart: next cycle prescaler=0, step_cnt=0, seg_o=0, levels=entry values, seg_start_o=1.
//    restart has priority over en and step_tick. Shadow duty still only follows at the period boundary.
//  rst_n low mid-operation: all state clears asynchronously to the reset values, any cycle.
// CONFIGURATION
//  `FADE_OUT_INV_EN defined: pwm_o[c] <= ~(pwm_cnt < duty[c]) and pwm_o resets to all-1s (active-low LEDs).
//  Not defined: polarity as above, and pwm_o resets to 0.
//  level_o is unaffected by the macro.
// STRUCTURE
//  fade_pkg: typedef enum logic[1:0] {HOLD_ON,RAMP_DN,HOLD_OFF,RAMP_UP} seg_kind_e;
//    localparam SEGMENTS=6; localparam seg_kind_e PROFILE[6]; function entry_level(kind,full).
//  Sub-module fade_pwm_ch (one per channel, generate loop): shadow duty register, comparator, output reg.
//    Inputs: pwm_cnt, wrap strobe, level.
//  Top: prescaler, step/segment counters, per-channel level registers, shared pwm_cnt.
// TESTING (CHANNELS=3, PWM_INTERVAL=10, STEP_INTERVAL=4, STEPS=5, CH_PHASE=2: STEP_VAL=2, 20 clk/segment)
//  1 Release rst_n, en=1 -> level_o={10,0,0}; after 4 clk ch1=2; after 20 clk ch1=10, seg_o=1,
//    seg_start_o pulses once; ch0 reaches 8 at the next tick.
//  2 Level 4 held -> pwm_o high exactly 4 of every 10 clk.
//    Level change mid-period -> old duty finishes; new duty starts at pwm_cnt 0.
//  3 en=0 for 50 clk mid RAMP_UP -> level_o, seg_o, step_cnt frozen; pwm_o keeps the same duty.
//    en=1 -> resumes the remaining prescaler count.
//  4 restart in segment 3 while en=0 -> next clk seg_o=0, level_o={10,0,0}, seg_start_o=1.
//  5 Run 120 clk -> seg_o sequence 0..5,0; 6 seg_start_o pulses.
//    STEPS=3 variant (STEP_VAL=3) -> ramp levels 3,6,10; no overshoot, no underflow on RAMP_DN.
//  6 Assert rst_n low mid-ramp for 1 clk -> immediate reset values.
//    With `FADE_OUT_INV_EN: pwm_o=3'b111 at reset and the level 10 channel stays constant 0.

Source files
------------

// File: rtl/fade_pkg.sv
// Shared types and helpers for the PWM fade sequencer: segment kinds, the
// colour-wheel profile and per-channel entry levels.
package fade_pkg;

  typedef enum logic [1:0] {
    HOLD_ON,
    RAMP_DN,
    HOLD_OFF,
    RAMP_UP
  } seg_kind_e;

  localparam int unsigned SEGMENTS = 6;

  localparam seg_kind_e PROFILE [SEGMENTS] = '{
    HOLD_ON, RAMP_DN, HOLD_OFF, HOLD_OFF, RAMP_UP, HOLD_ON
  };

  function automatic int unsigned entry_level(seg_kind_e kind, int unsigned full);
    return (kind == HOLD_ON || kind == RAMP_DN) ? full : 0;
  endfunction

  // phase_off must already be reduced mod SEGMENTS.
  function automatic seg_kind_e seg_kind(logic [2:0] seg, int unsigned phase_off);
    logic [2:0] idx;
    idx = 3'((32'(seg) + SEGMENTS - phase_off) % SEGMENTS);
    return PROFILE[idx];
  endfunction

endpackage

// File: rtl/fade_pwm_ch.sv
// One PWM channel: shadow duty reloaded at the period boundary, comparator and
// registered output. Defining FADE_OUT_INV_EN makes the output active-low.
module fade_pwm_ch #(
  parameter int unsigned     LW         = 4,
  parameter logic [LW-1:0]   RESET_DUTY = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [LW-1:0] pwm_cnt,
  input  logic          wrap,
  input  logic [LW-1:0] level,
  output logic          pwm
);

`ifdef FADE_OUT_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic [LW-1:0] duty_q, duty_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    duty_d = wrap ? level : duty_q;
    pwm_d  = (pwm_cnt < duty_q) ^ INV;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= RESET_DUTY;
      pwm_q  <= INV;
    end else begin
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/pwm_fade_engine.sv
// Multi-channel PWM fade sequencer: step prescaler, step/segment counters,
// per-channel level ramps and a shared PWM counter. Output polarity via FADE_OUT_INV_EN.
module pwm_fade_engine
  import fade_pkg::*;
#(
  parameter int unsigned CHANNELS      = 3,
  parameter int unsigned PWM_INTERVAL  = 1200,
  parameter int unsigned STEP_INTERVAL = 12000,
  parameter int unsigned STEPS         = 200,
  parameter int unsigned CH_PHASE      = 2,
  localparam int unsigned LW           = $clog2(PWM_INTERVAL + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   restart,
  output logic [CHANNELS*LW-1:0] level_o,
  output logic [CHANNELS-1:0]    pwm_o,
  output logic [2:0]             seg_o,
  output logic                   seg_start_o
);

  localparam int unsigned STEP_VAL  = PWM_INTERVAL / STEPS;
  localparam int unsigned PW        = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
  localparam int unsigned SW        = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(STEP_INTERVAL - 1);
  localparam logic [SW-1:0] STEP_MAX  = SW'(STEPS - 1);
  localparam logic [LW-1:0] FULL      = LW'(PWM_INTERVAL);
  localparam logic [LW-1:0] PWM_MAX   = LW'(PWM_INTERVAL - 1);

  if (STEP_VAL < 1 || PWM_INTERVAL < 2 || STEP_INTERVAL < 1) begin : g_param_err
    $error("pwm_fade_engine: need STEP_VAL>=1, PWM_INTERVAL>=2, STEP_INTERVAL>=1");
  end

  function automatic int unsigned ch_off(int unsigned c);
    return (CH_PHASE * c) % SEGMENTS;
  endfunction

  function automatic logic [LW-1:0] entry(int unsigned c);
    return LW'(entry_level(seg_kind(3'd0, ch_off(c)), PWM_INTERVAL));
  endfunction

  // Widened by one bit so the ramp-down borrow lands in the MSB.
  function automatic logic [LW-1:0] next_level(seg_kind_e kind, logic [LW-1:0] lvl,
                                               logic last);
    logic [LW:0] wide;
    wide = '0;
    unique case (kind)
      RAMP_UP: begin
        wide       = {1'b0, lvl} + (LW+1)'(STEP_VAL);
        next_level = (last || wide > {1'b0, FULL}) ? FULL : wide[LW-1:0];
      end
      RAMP_DN: begin
        wide       = {1'b0, lvl} - (LW+1)'(STEP_VAL);
        next_level = (last || wide[LW]) ? '0 : wide[LW-1:0];
      end
      HOLD_ON: next_level = FULL;
      default: next_level = '0;
    endcase
  endfunction

  logic [PW-1:0] presc_q, presc_d;
  logic [SW-1:0] step_q, step_d;
  logic [2:0]    seg_q, seg_d;
  logic          seg_start_q, seg_start_d;
  logic [LW-1:0] level_q [CHANNELS];
  logic [LW-1:0] level_d [CHANNELS];
  logic [LW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic          pwm_wrap;
  logic          step_tick;
  logic          seg_last;

  always_comb begin
    step_tick   = en && (presc_q == PRESC_MAX);
    seg_last    = (step_q == STEP_MAX);
    presc_d     = presc_q;
    step_d      = step_q;
    seg_d       = seg_q;
    seg_start_d = 1'b0;
    level_d     = level_q;

    if (restart) begin
      presc_d     = '0;
      step_d      = '0;
      seg_d       = 3'd0;
      seg_start_d = 1'b1;
      for (int unsigned c = 0; c < CHANNELS; c++) level_d[c] = entry(c);
    end else if (en) begin
      presc_d = step_tick ? '0 : presc_q + 1'b1;
      if (step_tick) begin
        if (seg_last) begin
          step_d      = '0;
          seg_d       = (seg_q == 3'd5) ? 3'd0 : seg_q + 3'd1;
          seg_start_d = 1'b1;
        end else begin
          step_d = step_q + 1'b1;
        end
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          level_d[c] = next_level(seg_kind(seg_q, ch_off(c)), level_q[c], seg_last);
        end
      end
    end
  end

  // PWM counter runs regardless of en/restart so outputs never glitch.
  always_comb begin
    pwm_wrap  = (pwm_cnt_q == PWM_MAX);
    pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q     <= '0;
      step_q      <= '0;
      seg_q       <= 3'd0;
      seg_start_q <= 1'b0;
      pwm_cnt_q   <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) level_q[c] <= entry(c);
    end else begin
      presc_q     <= presc_d;
      step_q      <= step_d;
      seg_q       <= seg_d;
      seg_start_q <= seg_start_d;
      pwm_cnt_q   <= pwm_cnt_d;
      level_q     <= level_d;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign level_o[c*LW +: LW] = level_q[c];

    fade_pwm_ch #(
      .LW         (LW),
      .RESET_DUTY (entry(c))
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .pwm_cnt (pwm_cnt_q),
      .wrap    (pwm_wrap),
      .level   (level_q[c]),
      .pwm     (pwm_o[c])
    );
  end

  assign seg_o       = seg_q;
  assign seg_start_o = seg_start_q;

endmodule

// File: tb/tb_pwm_fade_engine.sv
// Directed bench for pwm_fade_engine (PWM_INTERVAL=10, STEP_INTERVAL=4, STEPS=5 and a
// STEPS=3 variant); honours FADE_OUT_INV_EN for output polarity.
module tb_pwm_fade_engine;

  localparam int LW = 4;

`ifdef FADE_OUT_INV_EN
  localparam logic [2:0] INV = 3'b111;
`else
  localparam logic [2:0] INV = 3'b000;
`endif

  typedef struct {
    int cyc;
    int l0;
    int l1;
    int l2;
    int sg;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, restart = 1'b0;
  logic [11:0] level;
  logic [2:0]  pwm, seg;
  logic        seg_start;

  logic        rst3_n = 1'b0, en3 = 1'b0, restart3 = 1'b0;
  logic [11:0] level3;
  logic [2:0]  pwm3, seg3;
  logic        seg_start3;

  int tests = 0;
  int failed = 0;
  int cur = 0;
  logic [2:0] hist [0:255];
  logic [2:0] seg_hist [0:255];
  logic       ss_hist [0:255];

  pwm_fade_engine #(
    .CHANNELS(3), .PWM_INTERVAL(10), .STEP_INTERVAL(4), .STEPS(5), .CH_PHASE(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .restart(restart),
    .level_o(level), .pwm_o(pwm), .seg_o(seg), .seg_start_o(seg_start)
  );

  pwm_fade_engine #(
    .CHANNELS(3), .PWM_INTERVAL(10), .STEP_INTERVAL(4), .STEPS(3), .CH_PHASE(2)
  ) dut3 (
    .clk(clk), .rst_n(rst3_n), .en(en3), .restart(restart3),
    .level_o(level3), .pwm_o(pwm3), .seg_o(seg3), .seg_start_o(seg_start3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [11:0] lv, input logic [2:0] sg,
                           input vec_t v);
    chk($sformatf("%s@%0d ch0", tag, v.cyc), int'(lv[3:0]), v.l0);
    chk($sformatf("%s@%0d ch1", tag, v.cyc), int'(lv[7:4]), v.l1);
    chk($sformatf("%s@%0d ch2", tag, v.cyc), int'(lv[11:8]), v.l2);
    chk($sformatf("%s@%0d seg", tag, v.cyc), int'(sg), v.sg);
  endtask

  // Advance n clocks, sampling 1 time unit after each rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cur++;
      if (cur < 256) begin
        hist[cur]     = pwm ^ INV;
        seg_hist[cur] = seg;
        ss_hist[cur]  = seg_start;
      end
    end
  endtask

  function automatic int ones(input int ch, input int from, input int to);
    int n = 0;
    for (int k = from; k <= to; k++) n += int'(hist[k][ch]);
    return n;
  endfunction

  vec_t tab_a [15];
  vec_t tab_v [6];

  initial begin
    vec_t v;
    int pulses;
    int ss_bad;

    tab_a = '{
      '{0, 10, 0, 0, 0},   '{3, 10, 0, 0, 0},   '{4, 10, 2, 0, 0},   '{19, 10, 8, 0, 0},
      '{20, 10, 10, 0, 1}, '{24, 8, 10, 0, 1},  '{40, 0, 10, 0, 2},  '{44, 0, 10, 2, 2},
      '{60, 0, 10, 10, 3}, '{64, 0, 8, 10, 3},  '{84, 2, 0, 10, 4},  '{100, 10, 0, 10, 5},
      '{104, 10, 0, 8, 5}, '{120, 10, 0, 0, 0}, '{124, 10, 2, 0, 0}
    };
    tab_v = '{
      '{4, 10, 3, 0, 0},  '{8, 10, 6, 0, 0}, '{12, 10, 10, 0, 1},
      '{16, 7, 10, 0, 1}, '{20, 4, 10, 0, 1}, '{24, 0, 10, 0, 2}
    };

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst pwm", int'(pwm), int'(INV));
    chk("rst seg_start", int'(seg_start), 0);
    en = 1'b1;
    rst_n = 1'b1;
    cur = 0;
    seg_hist[0] = 3'd0;

    // Full 6-segment wheel from reset
    for (int i = 0; i < 15; i++) begin
      v = tab_a[i];
      tick(v.cyc - cur);
      chk_state("A", level, seg, v);
    end
    pulses = 0;
    ss_bad = 0;
    for (int k = 1; k <= 120; k++) begin
      pulses += int'(ss_hist[k]);
      if (ss_hist[k] != (seg_hist[k] != seg_hist[k-1])) ss_bad++;
    end
    chk("seg_start pulses", pulses, 6);
    chk("seg_start alignment", ss_bad, 0);
    chk("pwm ch1 per 1-10", ones(1, 1, 10), 0);
    chk("pwm ch1 per 11-20", ones(1, 11, 20), 4);
    chk("pwm ch1 per 21-30", ones(1, 21, 30), 8);
    chk("pwm ch1 start 11", int'(hist[11][1]), 1);
    chk("pwm ch1 off 15", int'(hist[15][1]), 0);
    chk("pwm ch1 start 21", int'(hist[21][1]), 1);
    chk("pwm ch0 full", ones(0, 1, 30), 30);
    chk("pwm ch2 zero", ones(2, 1, 30), 0);

    // Asynchronous reset mid-ramp, observed before any clock edge
    rst_n = 1'b0;
    #2;
    v = '{0, 10, 0, 0, 0};
    chk_state("ARST", level, seg, v);
    chk("arst seg_start", int'(seg_start), 0);
    chk("arst pwm", int'(pwm), int'(INV));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cur = 0;

    // Freeze mid RAMP_UP, then resume the remaining prescaler count
    tick(10);
    v = '{10, 10, 4, 0, 0};
    chk_state("C", level, seg, v);
    en = 1'b0;
    tick(50);
    v = '{60, 10, 4, 0, 0};
    chk_state("FRZ", level, seg, v);
    chk("frz pwm ch1 31-40", ones(1, 31, 40), 4);
    chk("frz pwm ch1 41-50", ones(1, 41, 50), 4);
    chk("frz pwm ch0", ones(0, 51, 60), 10);
    chk("frz pwm ch2", ones(2, 51, 60), 0);
    en = 1'b1;
    tick(1);
    chk("resume +1 ch1", int'(level[7:4]), 4);
    tick(1);
    chk("resume +2 ch1", int'(level[7:4]), 6);

    // Restart in segment 3 while frozen
    tick(50);
    v = '{112, 0, 10, 10, 3};
    chk_state("D", level, seg, v);
    en = 1'b0;
    restart = 1'b1;
    tick(1);
    restart = 1'b0;
    v = '{113, 10, 0, 0, 0};
    chk_state("RST", level, seg, v);
    chk("restart seg_start", int'(seg_start), 1);
    tick(1);
    chk("restart seg_start drop", int'(seg_start), 0);
    chk("restart seg hold", int'(seg), 0);
    tick(7);
    chk("restart ch0 old duty", ones(0, 113, 120), 0);
    chk("restart ch0 new duty", int'(hist[121][0]), 1);
    chk("restart ch1 old duty", ones(1, 113, 120), 8);
    chk("restart ch1 new duty", int'(hist[121][1]), 0);

    // STEPS=3 variant: ramp 3,6,10 and saturating ramp-down 10,7,4,0
    chk("v rst ch0", int'(level3[3:0]), 10);
    en3 = 1'b1;
    rst3_n = 1'b1;
    cur = 0;
    for (int i = 0; i < 6; i++) begin
      v = tab_v[i];
      tick(v.cyc - cur);
      chk_state("V", level3, seg3, v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
